// File: rtl/imm_gen_stage_if.sv
// Decode-stage immediate bus: input handshake (instr/format/tag), output handshake
// (immediate/tag/illegal) and the pipeline flush, bundled for imm_gen_stage.
interface imm_gen_stage_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [2:0]       imm_src;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport master (
        output flush, in_valid, instr, imm_src, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_illegal
    );

    modport slave (
        input  flush, in_valid, instr, imm_src, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_illegal
    );
endinterface

// File: rtl/imm_gen_stage.sv
// Registered RV32/RV64 immediate generator; 1 cycle from input transfer to out_valid.
// Backpressure: a 2-entry skid (main + skid register); in_ready drops while the skid holds an entry.
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    imm_gen_stage_if.slave bus
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_stage: XLEN must be 32 or 64");
        end
    endgenerate

    logic [XLEN-1:0]  imm_new;
    logic             ill_new;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_illegal_q, out_illegal_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             skid_illegal_q, skid_illegal_d;

    logic             in_xfer;

    // Opcode bits are decoded by the control unit, not here.
    logic unused_instr_lo;
    assign unused_instr_lo = ^bus.instr[6:0];

    always_comb begin
        imm_new = '0;
        ill_new = 1'b0;
        case (bus.imm_src)
            3'd0: imm_new = XLEN'($signed(bus.instr[31:20]));
            3'd1: imm_new = XLEN'($signed({bus.instr[31], bus.instr[7], bus.instr[30:25],
                                           bus.instr[11:8], 1'b0}));
            3'd2: imm_new = XLEN'($signed({bus.instr[31:12], 12'b0}));
            3'd3: imm_new = XLEN'($signed({bus.instr[31], bus.instr[19:12], bus.instr[20],
                                           bus.instr[30:21], 1'b0}));
            3'd4: imm_new = XLEN'($signed({bus.instr[31:25], bus.instr[11:7]}));
            3'd5: imm_new = XLEN'(bus.instr[19:15]);
            3'd6: imm_new = (XLEN == 64) ? XLEN'(bus.instr[25:20]) : XLEN'(bus.instr[24:20]);
            default: ill_new = 1'b1;
        endcase
    end

    assign in_xfer = bus.in_valid && !skid_valid_q;

    always_comb begin
        out_valid_d    = out_valid_q;
        out_imm_d      = out_imm_q;
        out_tag_d      = out_tag_q;
        out_illegal_d  = out_illegal_q;
        skid_valid_d   = skid_valid_q;
        skid_imm_d     = skid_imm_q;
        skid_tag_d     = skid_tag_q;
        skid_illegal_d = skid_illegal_q;

        if (bus.flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || bus.out_ready) begin
            // Main register is free this cycle: the older skid entry has priority.
            if (skid_valid_q) begin
                out_valid_d   = 1'b1;
                out_imm_d     = skid_imm_q;
                out_tag_d     = skid_tag_q;
                out_illegal_d = skid_illegal_q;
                skid_valid_d  = 1'b0;
            end else if (in_xfer) begin
                out_valid_d   = 1'b1;
                out_imm_d     = imm_new;
                out_tag_d     = bus.in_tag;
                out_illegal_d = ill_new;
            end else begin
                out_valid_d   = 1'b0;
            end
        end else if (in_xfer) begin
            skid_valid_d   = 1'b1;
            skid_imm_d     = imm_new;
            skid_tag_d     = bus.in_tag;
            skid_illegal_d = ill_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_imm_q      <= '0;
            out_tag_q      <= '0;
            out_illegal_q  <= 1'b0;
            skid_valid_q   <= 1'b0;
            skid_imm_q     <= '0;
            skid_tag_q     <= '0;
            skid_illegal_q <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_imm_q      <= out_imm_d;
            out_tag_q      <= out_tag_d;
            out_illegal_q  <= out_illegal_d;
            skid_valid_q   <= skid_valid_d;
            skid_imm_q     <= skid_imm_d;
            skid_tag_q     <= skid_tag_d;
            skid_illegal_q <= skid_illegal_d;
        end
    end

    assign bus.in_ready    = !skid_valid_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = out_imm_q;
    assign bus.out_tag     = out_tag_q;
    assign bus.out_illegal = out_illegal_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: RV32 and RV64 instances share one stimulus stream and are
// checked every cycle against an in-order queue model plus directed literal cases.
module tb_imm_gen_stage;
    localparam int TAG_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             out_ready;
    logic [31:0]      instr;
    logic [2:0]       imm_src;
    logic [TAG_W-1:0] in_tag;

    imm_gen_stage_if #(.XLEN(32), .TAG_W(TAG_W)) if32 ();
    imm_gen_stage_if #(.XLEN(64), .TAG_W(TAG_W)) if64 ();

    assign if32.flush     = flush;
    assign if32.in_valid  = in_valid;
    assign if32.instr     = instr;
    assign if32.imm_src   = imm_src;
    assign if32.in_tag    = in_tag;
    assign if32.out_ready = out_ready;
    assign if64.flush     = flush;
    assign if64.in_valid  = in_valid;
    assign if64.instr     = instr;
    assign if64.imm_src   = imm_src;
    assign if64.in_tag    = in_tag;
    assign if64.out_ready = out_ready;

    imm_gen_stage #(.XLEN(32), .TAG_W(TAG_W)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));
    imm_gen_stage #(.XLEN(64), .TAG_W(TAG_W)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64.slave));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic longint sext(input longint val, input int bits);
        return (val <<< (64 - bits)) >>> (64 - bits);
    endfunction

    // Immediate straight from the format rules, using shifts and masks on a 64-bit integer.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                            input int xlen);
        longint x;
        longint v;
        x = 0;
        x[31:0] = ins;
        case (src)
            3'd0: v = sext(x >> 20, 12);
            3'd1: v = sext((((x >> 31) & 1) << 12) | (((x >> 7) & 1) << 11) |
                           (((x >> 25) & 63) << 5) | (((x >> 8) & 15) << 1), 13);
            3'd2: v = sext(x & 64'hFFFF_F000, 32);
            3'd3: v = sext((((x >> 31) & 1) << 20) | (((x >> 12) & 255) << 12) |
                           (((x >> 20) & 1) << 11) | (((x >> 21) & 1023) << 1), 21);
            3'd4: v = sext(((x >> 25) << 5) | ((x >> 7) & 31), 12);
            3'd5: v = (x >> 15) & 31;
            3'd6: v = (xlen == 64) ? ((x >> 20) & 63) : ((x >> 20) & 31);
            default: v = 0;
        endcase
        if (xlen == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    typedef struct {
        logic [31:0]      instr;
        logic [2:0]       src;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t mq[$];
    bit   accept;

    // Model: entries held in arrival order, at most two, in_ready while fewer than two.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            mq.delete();
        end else begin
            accept = in_valid && (mq.size() < 2);
            if (out_ready && mq.size() > 0) void'(mq.pop_front());
            if (accept) mq.push_back(ent_t'{instr, imm_src, in_tag});
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready32", if32.in_ready, mq.size() < 2);
            chk("in_ready64", if64.in_ready, mq.size() < 2);
            chk("out_valid32", if32.out_valid, mq.size() > 0);
            chk("out_valid64", if64.out_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("imm32", if32.out_imm, ref_imm(mq[0].instr, mq[0].src, 32));
                chk("imm64", if64.out_imm, ref_imm(mq[0].instr, mq[0].src, 64));
                chk("tag32", if32.out_tag, mq[0].tag);
                chk("tag64", if64.out_tag, mq[0].tag);
                chk("ill32", if32.out_illegal, mq[0].src == 3'd7);
                chk("ill64", if64.out_illegal, mq[0].src == 3'd7);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] i, input logic [2:0] s, input logic [TAG_W-1:0] t);
        in_valid = 1'b1;
        instr    = i;
        imm_src  = s;
        in_tag   = t;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; imm_src = '0; in_tag = '0;

        chk("pin_model_I", ref_imm(32'hFFF0_0093, 3'd0, 32), 64'hFFFF_FFFF);
        chk("pin_model_S", ref_imm(32'hFE20_AC23, 3'd4, 64), 64'hFFFF_FFFF_FFFF_FFF8);
        chk("pin_model_SHAMT64", ref_imm(32'h0200_0000, 3'd6, 64), 64'h20);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid32", if32.out_valid, 0);
        chk("rst_imm32", if32.out_imm, 0);
        chk("rst_tag32", if32.out_tag, 0);
        chk("rst_ill32", if32.out_illegal, 0);
        chk("rst_valid64", if64.out_valid, 0);
        chk("rst_imm64", if64.out_imm, 0);
        rst_n = 1'b1;
        tick();
        chk("in_ready_after_reset", if32.in_ready, 1);

        out_ready = 1'b1;
        send(32'hFFF0_0093, 3'd0, 8'd5); tick(); in_valid = 1'b0;
        chk("I_valid", if32.out_valid, 1);
        chk("I_imm32", if32.out_imm, 64'hFFFF_FFFF);
        chk("I_imm64", if64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);

        send(32'hFE00_0EE3, 3'd1, 8'd6); tick();
        chk("B_imm32", if32.out_imm, 64'hFFFF_FFFC);
        send(32'hFE20_AC23, 3'd4, 8'd7); tick(); in_valid = 1'b0;
        chk("S_valid_no_bubble", if32.out_valid, 1);
        chk("S_imm32", if32.out_imm, 64'hFFFF_FFF8);
        tick();

        send(32'h1234_50B7, 3'd2, 8'd8); tick();
        chk("U_imm64", if64.out_imm, 64'h0000_0000_1234_5000);
        send(32'h0080_006F, 3'd3, 8'd9); tick(); in_valid = 1'b0;
        chk("J_imm64", if64.out_imm, 64'h0000_0000_0000_0008);
        tick();

        out_ready = 1'b0;
        send($urandom(), 3'd0, 8'd1); tick();
        send($urandom(), 3'd0, 8'd2); tick();
        chk("bp_in_ready_low", if32.in_ready, 0);
        send($urandom(), 3'd0, 8'd3); tick();
        chk("bp_tag3_held_off", if32.in_ready, 0);
        chk("bp_first_tag", if32.out_tag, 1);
        out_ready = 1'b1; tick();
        chk("bp_second_tag", if32.out_tag, 2);
        tick(); in_valid = 1'b0;
        chk("bp_third_tag", if32.out_tag, 3);
        tick();
        chk("bp_drained", if32.out_valid, 0);

        out_ready = 1'b0;
        send($urandom(), 3'd0, 8'd10); tick();
        send($urandom(), 3'd0, 8'd11); tick();
        chk("fl_full", if32.in_ready, 0);
        send($urandom(), 3'd0, 8'd12); flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", if32.out_valid, 0);
        chk("fl_in_ready", if32.in_ready, 1);
        out_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("fl_never_emitted", if64.out_valid, 0);
        end

        send($urandom(), 3'd7, 8'd13); tick(); in_valid = 1'b0;
        chk("ill_flag32", if32.out_illegal, 1);
        chk("ill_imm32", if32.out_imm, 0);
        chk("ill_imm64", if64.out_imm, 0);
        tick();

        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            instr     = $urandom();
            imm_src   = 3'($urandom_range(0, 7));
            in_tag    = TAG_W'($urandom());
            out_ready = ($urandom_range(0, 3) < ((c < 1500) ? 1 : 3));
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush = 1'b0;

        out_ready = 1'b0;
        send($urandom(), 3'd0, 8'd20); tick(); in_valid = 1'b0;
        chk("mid_rst_pre_valid", if32.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid32", if32.out_valid, 0);
        chk("mid_rst_valid64", if64.out_valid, 0);
        #10 rst_n = 1'b1;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
